// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: shared state encoding and counter widths for the fill controller
package cache_fill_fsm_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;
  localparam int CNT_W = 4;
  localparam int OFFSET_W = 3;
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: 4-bit word counter register with increment and priority clear
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_we;
  always_comb begin
    cnt_we = clr || inc;
    cnt_nxt = clr ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (cnt_we) cnt <= cnt_nxt;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a miss, issues one word read per cycle for a block and steers returns into the cache
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  input  logic                memory_data_valid,
  output logic                fsm_busy,
  output logic                memory_read_en,
  output logic [ADDR_W-1:0]   memory_address,
  output logic                write_data_array,
  output logic [OFFSET_W-1:0] word_offset,
  output logic                write_tag_array
);
  localparam int LOW_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LOW_W) - 1);
  localparam logic [CNT_W-1:0] WPB = CNT_W'(WORDS_PER_BLOCK);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] blk_addr;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              fill, start, last;
  always_comb begin
    fill = state == ST_FILL;
    start = !fill && miss_detected;
    fsm_busy = fill;
    memory_read_en = fill && issue_cnt < WPB;
    memory_address = fill ? blk_addr | ADDR_W'({issue_cnt[OFFSET_W-1:0], 1'b0}) : '0;
    write_data_array = fill && memory_data_valid;
    word_offset = fill ? recv_cnt[OFFSET_W-1:0] : '0;
    last = write_data_array && recv_cnt == WPB - 1'b1;
    write_tag_array = last;
    state_nxt = fill ? (last ? ST_IDLE : ST_FILL) : (start ? ST_FILL : ST_IDLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      blk_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start) blk_addr <= miss_address & ~LOW_MASK;
    end
  fill_counter u_issue (
    .clk(clk),
    .rst(rst),
    .inc(memory_read_en),
    .clr(start),
    .cnt(issue_cnt)
  );
  fill_counter u_recv (
    .clk(clk),
    .rst(rst),
    .inc(write_data_array),
    .clr(start),
    .cnt(recv_cnt)
  );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed checks of fill sequencing, completion, reset and stray-valid handling
module tb_cache_fill_fsm;
  logic        clk = 0;
  logic        rst = 0;
  logic        miss_detected = 0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 0;
  logic        fsm_busy, memory_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0]  word_offset;
  int          errors = 0;
  int          checks = 0;
  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy),
    .memory_read_en(memory_read_en),
    .memory_address(memory_address),
    .write_data_array(write_data_array),
    .word_offset(word_offset),
    .write_tag_array(write_tag_array)
  );
  always #5 clk = ~clk;
  function automatic logic v4(int r);
    return r >= 5 && r <= 12;
  endfunction
  function automatic logic [6:0] exp4(int r);
    logic busy, rd, wde, tag;
    logic [2:0] off;
    busy = r >= 1 && r <= 12;
    rd = r >= 1 && r <= 8;
    wde = v4(r);
    tag = r == 12;
    off = wde ? 3'(r - 5) : 3'd0;
    return {busy, rd, wde, tag, off};
  endfunction
  function automatic logic [6:0] got_ctl();
    return {fsm_busy, memory_read_en, write_data_array, write_tag_array, fsm_busy ? word_offset : 3'd0};
  endfunction
  task automatic step(input logic m, input logic [15:0] a, input logic v);
    @(negedge clk);
    miss_detected = m;
    miss_address = a;
    memory_data_valid = v;
    #1;
  endtask
  task automatic test_reset();
    miss_detected = 1;
    miss_address = 16'h1237;
    memory_data_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({fsm_busy, memory_read_en, memory_address, write_data_array, word_offset, write_tag_array} !== 22'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got busy=%b rd=%b addr=%h wde=%b off=%0d tag=%b, want all 0", i, fsm_busy, memory_read_en, memory_address, write_data_array, word_offset, write_tag_array);
      end
    end
    @(negedge clk);
    miss_detected = 0;
    memory_data_valid = 0;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      step(0, 16'h0, 0);
      checks++;
      if ({fsm_busy, memory_read_en} !== 2'b00) begin
        errors++;
        $display("FAIL reset_release_idle cycle %0d: got busy=%b rd=%b, want 0 0", i, fsm_busy, memory_read_en);
      end
    end
  endtask
  task automatic test_basic_fill();
    int tags = 0;
    step(1, 16'h1237, 0);
    checks++;
    if ({fsm_busy, memory_read_en} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b rd=%b, want 0 0", fsm_busy, memory_read_en);
    end
    for (int r = 1; r <= 13; r++) begin
      step(0, 16'h0, v4(r));
      tags += int'(write_tag_array);
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL basic_ctl r=%0d: got {busy,rd,wde,tag,off}=%b, want %b", r, got_ctl(), exp4(r));
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'h1230 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL basic_addr r=%0d: got %h, want %h", r, memory_address, 16'h1230 + 16'(2 * (r - 1)));
        end
      end
    end
    checks++;
    if (tags !== 1) begin
      errors++;
      $display("FAIL basic_tag_count: got %0d, want 1", tags);
    end
  endtask
  task automatic test_back_to_back();
    step(1, 16'h0040, 0);
    for (int r = 1; r <= 12; r++) begin
      step(1, 16'h0040, v4(r));
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL b2b_first_ctl r=%0d: got %b, want %b", r, got_ctl(), exp4(r));
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'h0040 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL b2b_first_addr r=%0d: got %h, want %h", r, memory_address, 16'h0040 + 16'(2 * (r - 1)));
        end
      end
    end
    step(1, 16'h0040, 0);
    checks++;
    if ({fsm_busy, memory_read_en} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b rd=%b, want 0 0", fsm_busy, memory_read_en);
    end
    for (int r = 1; r <= 13; r++) begin
      step(0, 16'h0, v4(r));
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL b2b_second_ctl r=%0d: got %b, want %b", r, got_ctl(), exp4(r));
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'h0040 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL b2b_second_addr r=%0d: got %h, want %h", r, memory_address, 16'h0040 + 16'(2 * (r - 1)));
        end
      end
    end
  endtask
  task automatic test_jitter();
    logic jit [13] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1};
    int nv = 0;
    int tags = 0;
    logic v;
    logic [6:0] exp_v;
    step(1, 16'h0300, 0);
    for (int r = 1; r <= 15; r++) begin
      v = (r >= 2 && r <= 14) ? jit[r - 2] : 1'b0;
      step(0, 16'h0, v);
      exp_v = {nv < 8, r <= 8, v, v && nv == 7, nv < 8 ? 3'(nv) : 3'd0};
      tags += int'(write_tag_array);
      checks++;
      if (got_ctl() !== exp_v) begin
        errors++;
        $display("FAIL jitter_ctl r=%0d: got %b, want %b", r, got_ctl(), exp_v);
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'h0300 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL jitter_addr r=%0d: got %h, want %h", r, memory_address, 16'h0300 + 16'(2 * (r - 1)));
        end
      end
      if (v) nv++;
    end
    checks++;
    if (tags !== 1) begin
      errors++;
      $display("FAIL jitter_tag_count: got %0d, want 1", tags);
    end
  endtask
  task automatic test_reset_mid_fill();
    int tags = 0;
    step(1, 16'h1000, 0);
    for (int r = 1; r <= 7; r++) begin
      step(0, 16'h0, v4(r));
      tags += int'(write_tag_array);
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL midrst_pre_ctl r=%0d: got %b, want %b", r, got_ctl(), exp4(r));
      end
    end
    @(negedge clk);
    rst = 0;
    miss_detected = 1;
    memory_data_valid = 1;
    #1;
    tags += int'(write_tag_array);
    checks++;
    if ({fsm_busy, memory_read_en, memory_address, write_data_array, word_offset, write_tag_array} !== 22'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b rd=%b addr=%h wde=%b off=%0d tag=%b, want all 0", fsm_busy, memory_read_en, memory_address, write_data_array, word_offset, write_tag_array);
    end
    checks++;
    if (tags !== 0) begin
      errors++;
      $display("FAIL midrst_no_tag: got %0d tag writes, want 0", tags);
    end
    @(negedge clk);
    miss_detected = 0;
    memory_data_valid = 0;
    rst = 1;
    tags = 0;
    step(1, 16'hABC0, 0);
    for (int r = 1; r <= 13; r++) begin
      step(0, 16'h0, v4(r));
      tags += int'(write_tag_array);
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL midrst_refill_ctl r=%0d: got %b, want %b", r, got_ctl(), exp4(r));
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'hABC0 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL midrst_refill_addr r=%0d: got %h, want %h", r, memory_address, 16'hABC0 + 16'(2 * (r - 1)));
        end
      end
    end
    checks++;
    if (tags !== 1) begin
      errors++;
      $display("FAIL midrst_refill_tag_count: got %0d, want 1", tags);
    end
  endtask
  task automatic test_stray_valid();
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0, 1);
      checks++;
      if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
        errors++;
        $display("FAIL stray_idle i=%0d: got busy=%b wde=%b tag=%b, want 0 0 0", i, fsm_busy, write_data_array, write_tag_array);
      end
    end
    step(1, 16'h2468, 0);
    for (int r = 1; r <= 13; r++) begin
      step(0, 16'h0, v4(r));
      checks++;
      if (got_ctl() !== exp4(r)) begin
        errors++;
        $display("FAIL stray_fill_ctl r=%0d: got %b, want %b", r, got_ctl(), exp4(r));
      end
      if (r <= 8) begin
        checks++;
        if (memory_address !== 16'h2460 + 16'(2 * (r - 1))) begin
          errors++;
          $display("FAIL stray_fill_addr r=%0d: got %h, want %h", r, memory_address, 16'h2460 + 16'(2 * (r - 1)));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic_fill();
    test_back_to_back();
    test_jitter();
    test_reset_mid_fill();
    test_stray_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between a cache's hit/miss logic and the multi-cycle main memory.
- On a miss it issues one word-read per cycle for a whole block, then steers each returning word into the cache data array.
- On the final word it writes the tag array.
- Its two word counters are 4-bit registers built from the team's 4-bit register primitive; this block generates their next-value and write-enable signals.

Parameters:
- WORDS_PER_BLOCK, 8: words per cache block; power of two, 2..8.
- ADDR_W, 16: byte-address width. Words are 16-bit, so byte offset bit 0 is always 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE.
- miss_address  in  ADDR_W  byte address of the missing access; sampled with miss_detected.
- memory_data_valid  in  1  memory returns one word this cycle, in issue order.
- fsm_busy  out  1  fill in progress; the pipeline stalls while high.
- memory_read_en  out  1  issue one word read this cycle.
- memory_address  out  ADDR_W  word address for the current read.
- write_data_array  out  1  write the returning word into the data array.
- word_offset  out  3  word index within the block for write_data_array.
- write_tag_array  out  1  write tag and valid bit for the filled block.

Behaviour:
- States: IDLE=0, FILL=1. A 1-bit state register is sufficient.
- Reset (rst=0, any time, asynchronous):
  - state=IDLE; issue_cnt=0; recv_cnt=0; blk_addr=0.
  - All outputs 0.
  - Reset mid-fill abandons the fill; no tag write occurs.
- IDLE:
  - fsm_busy=0. memory_read_en, write_data_array and write_tag_array are 0.
  - memory_data_valid is ignored.
  - If miss_detected=1 at a clock edge: latch blk_addr = miss_address with its low log2(WORDS_PER_BLOCK)+1 bits cleared; clear both counters; go to FILL.
- FILL:
  - fsm_busy=1.
  - Issue side:
    - memory_read_en = (issue_cnt < WORDS_PER_BLOCK).
    - memory_address = blk_addr | (issue_cnt[2:0] << 1).
    - issue_cnt increments each cycle read_en=1. Reads are issued on consecutive cycles with no gaps.
  - Receive side:
    - write_data_array = memory_data_valid.
    - word_offset = recv_cnt[2:0].
    - recv_cnt increments on each valid.
  - Completion:
    - When memory_data_valid=1 and recv_cnt = WORDS_PER_BLOCK-1, write_tag_array=1 in the same cycle as the last data write.
    - Next state is IDLE. fsm_busy falls the following cycle.
- Counters are 4 bits so that the value WORDS_PER_BLOCK is representable. issue_cnt saturates at WORDS_PER_BLOCK.
- Simultaneous issue and receive in one cycle is legal and normal; both counters advance.
- miss_detected in FILL is ignored and is not queued. The cache re-asserts it after the fill completes.
- Spurious memory_data_valid in IDLE has no effect.
- Latency:
  - First read is issued 1 cycle after miss_detected is sampled.
  - Fill completes on the cycle of the WORDS_PER_BLOCK-th valid.
  - The block imposes no fixed memory latency; it relies on in-order returns.
- All outputs are Moore-decoded from state and counters, except write_data_array and write_tag_array, which combine state with memory_data_valid.

Decomposition:
- Shared package holds:
  - state constants ST_IDLE=1'b0, ST_FILL=1'b1;
  - CNT_W=4;
  - OFFSET_W=3.
- Sub-module fill_counter:
  - 4-bit register (4-bit register primitive) plus incrementer, with inc and clr inputs; clr has priority.
  - Instantiated twice, for issue_cnt and recv_cnt.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with miss_detected=1 and memory_data_valid=1.
  - Required: all outputs 0.
  - Stimulus: release rst.
  - Required: block stays IDLE; fsm_busy=0.
- Basic fill with memory model latency 4:
  - Stimulus: miss_address=0x1237.
  - Required, reads: read_en high for 8 consecutive cycles, addresses 0x1230, 0x1232 … 0x123E.
  - Required, writes: valid cycles 5..12 give word_offset 0..7.
  - Required, completion: write_tag_array exactly once, on the offset-7 cycle; fsm_busy low the next cycle.
- Back-to-back misses:
  - Stimulus: miss_detected held high throughout a fill at 0x0040.
  - Required: no second fill starts mid-fill; the next fill starts 1 cycle after fsm_busy falls.
- Jittered returns:
  - Stimulus: valid arriving with gaps (pattern 1,0,0,1,1,0,1,…).
  - Required: word_offset advances only on valid; tag written on the 8th valid.
- Reset mid-fill:
  - Stimulus: assert rst after 3 valids.
  - Required: outputs 0 immediately; no tag write.
  - Stimulus: new miss at 0xABC0.
  - Required: reads restart at offset 0.
- Stray valid:
  - Stimulus: memory_data_valid pulses in IDLE.
  - Required: write_data_array stays 0; counters unchanged; the next fill is correct.
